// File: rtl/pipe_exe_div.sv
// Iterative radix-2 restoring divider for the EX stage (DIV / DIVU).
// One quotient bit per cycle; results valid WIDTH+1 cycles after start.
module pipe_exe_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_dvd;      // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0] r_dsr;      // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_dvd_nx;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_dsr_zero;

  // One restoring iteration plus operand magnitude conversion
  always_comb begin
    w_shift    = {r_rem, r_dvd[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dsr};
    w_qbit     = ~w_diff[WIDTH];
    w_rem_nx   = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_dvd_nx   = {r_dvd[WIDTH-2:0], w_qbit};
    w_last     = (r_count == CW'(WIDTH - 1));
    w_dvd_mag  = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    w_dsr_mag  = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    w_dsr_zero = (divisor == '0);
  end

  // Control FSM, datapath registers and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!flush && start) begin
            // Divide by zero leaves the all-ones quotient uncorrected; the
            // remainder correction still reproduces the raw dividend.
            r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & ~w_dsr_zero;
            r_neg_r <= is_signed & dividend[WIDTH-1];
            r_dvd   <= w_dvd_mag;
            r_dsr   <= w_dsr_mag;
            r_rem   <= '0;
            r_count <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem   <= w_rem_nx;
            r_dvd   <= w_dvd_nx;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= r_neg_q ? -w_dvd_nx : w_dvd_nx;
              r_remd  <= r_neg_r ? -w_rem_nx : w_rem_nx;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign stall     = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_BUSY);

endmodule

// File: tb/tb_pipe_exe_div.sv
// Self-checking bench for pipe_exe_div: directed corner cases plus
// randomized divides against an arithmetic reference model.
module tb_pipe_exe_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        stall;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] last_q;
  logic [31:0] last_r;

  pipe_exe_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .quotient(quotient), .remainder(remainder), .done(done),
    .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic with truncating signed division
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts a divide at the current negedge (cycle 0) and holds start through
  // DONE; returns at the negedge of the following IDLE cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] e;
    int lat;
    e         = ref_div(a, b, s);
    lat       = 999;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (done) begin
        lat = c;
        check("stall_in_done", {31'd0, stall}, 32'd0);
        break;
      end
      check("stall_while_busy", {31'd0, stall}, 32'd1);
      next_cycle();
    end
    check("latency", lat, 32'd33);
    check("quotient", quotient, e[63:32]);
    check("remainder", remainder, e[31:0]);
    last_q = e[63:32];
    last_r = e[31:0];
    next_cycle();
  endtask

  task automatic idle_check(input string tag);
    start = 1'b0;
    #1;
    check(tag, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic done_seen;
    logic [31:0] ra, rb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_flags", {29'd0, done, busy, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Directed divides
    do_div(32'd100, 32'd7, 1'b0);              idle_check("idle_after_divu");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);        idle_check("idle_after_div_neg");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1);        idle_check("idle_after_div_negd");
    do_div(32'h1234_5678, 32'd0, 1'b0);        idle_check("idle_after_div0u");
    do_div(32'h8765_4321, 32'd0, 1'b1);        idle_check("idle_after_div0s");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); idle_check("idle_after_ovf");

    // Flush in the middle of BUSY
    next_cycle();
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 0; c < 10; c++) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_busy_stall", {30'd0, busy, stall}, 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      #1;
      if (done) done_seen = 1'b1;
    end
    check("flush_no_done", {31'd0, done_seen}, 32'd0);
    check("flush_q_kept", quotient, last_q);
    check("flush_r_kept", remainder, last_r);
    @(negedge clk);
    do_div(32'd9, 32'd3, 1'b0);                idle_check("idle_after_9_3");

    // Flush coinciding with the last BUSY cycle
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    for (int c = 0; c < 32; c++) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0; start = 1'b0;
    #1;
    check("late_flush_done", {30'd0, done, busy}, 32'd0);
    check("late_flush_q_kept", quotient, last_q);
    check("late_flush_r_kept", remainder, last_r);
    next_cycle();

    // Asynchronous reset mid-operation
    start = 1'b1; is_signed = 1'b1; dividend = 32'h0000_1234; divisor = 32'd17;
    for (int c = 0; c < 20; c++) next_cycle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", quotient, 32'd0);
    check("async_rst_r", remainder, 32'd0);
    start = 1'b0;
    #1;
    check("async_rst_flags", {29'd0, done, busy, stall}, 32'd0);
    last_q = '0; last_r = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    check("post_rst_idle", {29'd0, done, busy, stall}, 32'd0);
    @(negedge clk);

    // Back-to-back: second start in the IDLE cycle after DONE
    do_div(32'd50, 32'd5, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd16, 1'b0);       idle_check("idle_after_b2b");

    // Randomized divides, some chained back-to-back
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -($urandom_range(1, 15));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_div(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_check("idle_after_rand");
    end
    idle_check("idle_final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
